// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
// Runs 8259A-style interrupt-acknowledge cycles. It raises INT to the CPU and
// counts INTA_n pulses. It provides the byte for Data_bus and its drive enable
// (CALL/address bytes in 8080 mode, a vector in 8086 mode). It also freezes the
// priority resolver and issues ISR set/clear pulses.
module pic_inta_sequencer #(
   parameter logic [7:0] CALL_OPCODE = 8'hCD,
   parameter logic [2:0] SPURIOUS_IR = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       INTA_n,
   input  logic       int_pending,
   input  logic [2:0] int_level,
   input  logic       mode_8086,
   input  logic       aeoi,
   input  logic       interval4,
   input  logic [4:0] vec_base,
   input  logic [2:0] addr_lo,
   input  logic [7:0] addr_hi,
   output logic       INT,
   output logic [7:0] bus_data,
   output logic       bus_drive,
   output logic       freeze,
   output logic       isr_set,
   output logic       isr_clr,
   output logic [2:0] isr_level,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;

   state_t     state;
   logic       inta_q;     // INTA_n delayed one clk, for edge detection
   logic       mode_q;     // 8086 mode latched at the first fall
   logic       aeoi_q;     // auto-EOI latched at the first fall
   logic       spur_q;     // no valid request at the first fall
   logic [2:0] level_q;    // level latched at the first fall

   logic       fall;
   logic       rise;
   logic [2:0] fall_level;
   logic [7:0] ack2_byte;

   // Edge detection, the level to latch on a fall, and the second-byte encoding
   always_comb begin
      // NOTE: a default assignment at the top of every always_comb keeps each path assigned, so no latch is inferred.
      fall       = 1'b0;
      rise       = 1'b0;
      fall_level = SPURIOUS_IR;
      ack2_byte  = 8'h00;
      fall = inta_q & ~INTA_n;
      rise = ~inta_q & INTA_n;
      if (int_pending) fall_level = int_level;
      // The ICW fields are sampled live. Only the mode is frozen, and it is frozen by mode_q.
      if (mode_q)         ack2_byte = {vec_base, level_q};
      else if (interval4) ack2_byte = {addr_lo[2:0], level_q, 2'b00};
      else                ack2_byte = {addr_lo[2:1], level_q, 3'b000};
   end

   // Acknowledge FSM. Every output is registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: every register is reset, including the latched context, so an abort leaves nothing stale.
         state     <= IDLE;
         inta_q    <= 1'b1;
         mode_q    <= 1'b0;
         aeoi_q    <= 1'b0;
         spur_q    <= 1'b0;
         level_q   <= 3'd0;
         INT       <= 1'b0;
         bus_data  <= 8'h00;
         bus_drive <= 1'b0;
         freeze    <= 1'b0;
         isr_set   <= 1'b0;
         isr_clr   <= 1'b0;
         isr_level <= 3'd0;
         busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register see the pre-edge values, as the hardware does.
         inta_q  <= INTA_n;
         isr_set <= 1'b0;
         isr_clr <= 1'b0;
         unique case (state)
            IDLE: begin
               INT <= int_pending;
               if (fall) begin
                  // A fall is accepted even when INT is low. In that case it is handled as spurious.
                  state     <= ACK1;
                  INT       <= 1'b0;
                  mode_q    <= mode_8086;
                  aeoi_q    <= aeoi;
                  spur_q    <= ~int_pending;
                  level_q   <= fall_level;
                  isr_level <= fall_level;
                  isr_set   <= int_pending;
                  freeze    <= 1'b1;
                  busy      <= 1'b1;
                  bus_drive <= ~mode_8086;
                  if (!mode_8086) bus_data <= CALL_OPCODE;
               end
            end
            ACK1: begin
               if (rise) begin
                  bus_drive <= 1'b0;
                  state     <= ACK2;
               end
            end
            ACK2: begin
               if (rise) begin
                  bus_drive <= 1'b0;
                  if (mode_q) begin
                     state   <= IDLE;
                     freeze  <= 1'b0;
                     busy    <= 1'b0;
                     isr_clr <= aeoi_q & ~spur_q;
                  end else begin
                     state <= ACK3;
                  end
               end else if (!INTA_n) begin
                  bus_drive <= 1'b1;
                  bus_data  <= ack2_byte;
               end
            end
            ACK3: begin
               if (rise) begin
                  state     <= IDLE;
                  bus_drive <= 1'b0;
                  freeze    <= 1'b0;
                  busy      <= 1'b0;
                  isr_clr   <= aeoi_q & ~spur_q;
               end else if (!INTA_n) begin
                  bus_drive <= 1'b1;
                  bus_data  <= addr_hi;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer
// Directed scenarios for pic_inta_sequencer. Expected values are worked out by
// hand. Inputs change #1 after a rising edge. Outputs are sampled #1 after the
// rising edge that registers the response.
module tb_pic_inta_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       INTA_n;
   logic       int_pending;
   logic [2:0] int_level;
   logic       mode_8086;
   logic       aeoi;
   logic       interval4;
   logic [4:0] vec_base;
   logic [2:0] addr_lo;
   logic [7:0] addr_hi;
   logic       INT;
   logic [7:0] bus_data;
   logic       bus_drive;
   logic       freeze;
   logic       isr_set;
   logic       isr_clr;
   logic [2:0] isr_level;
   logic       busy;

   int checks = 0;
   int passed = 0;

   pic_inta_sequencer dut (
      .clk(clk), .reset(reset), .INTA_n(INTA_n), .int_pending(int_pending),
      .int_level(int_level), .mode_8086(mode_8086), .aeoi(aeoi),
      .interval4(interval4), .vec_base(vec_base), .addr_lo(addr_lo),
      .addr_hi(addr_hi), .INT(INT), .bus_data(bus_data), .bus_drive(bus_drive),
      .freeze(freeze), .isr_set(isr_set), .isr_clr(isr_clr),
      .isr_level(isr_level), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; INTA_n = 1'b1; int_pending = 1'b0; int_level = 3'd0;
      mode_8086 = 1'b0; aeoi = 1'b0; interval4 = 1'b0; vec_base = 5'd0;
      addr_lo = 3'd0; addr_hi = 8'd0;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({INT, bus_data, bus_drive, freeze, isr_set, isr_clr, isr_level, busy} !== 16'h0)
         $display("FAIL reset_outputs: got INT=%b data=%h drv=%b frz=%b set=%b clr=%b lvl=%0d busy=%b, want all 0",
                  INT, bus_data, bus_drive, freeze, isr_set, isr_clr, isr_level, busy);
      else passed++;
   endtask

   task automatic test_8086();
      do_reset();
      mode_8086 = 1'b1; vec_base = 5'h08; int_level = 3'd3; int_pending = 1'b1;
      step(1);
      checks++; if (INT !== 1'b1) $display("FAIL 8086_int_raise: got %b want 1", INT); else passed++;
      INTA_n = 1'b0; step(1);
      checks++; if (INT !== 1'b0) $display("FAIL 8086_int_drop: got %b want 0", INT); else passed++;
      checks++; if ({isr_set, isr_level} !== {1'b1, 3'd3})
         $display("FAIL 8086_isr_set: got set=%b lvl=%0d want set=1 lvl=3", isr_set, isr_level); else passed++;
      checks++; if ({bus_drive, freeze, busy} !== 3'b011)
         $display("FAIL 8086_ack1_flags: got drv/frz/busy=%b want 011", {bus_drive, freeze, busy}); else passed++;
      step(1);
      checks++; if (isr_set !== 1'b0) $display("FAIL 8086_isr_set_pulse: got %b want 0", isr_set); else passed++;
      INTA_n = 1'b1; step(2);
      checks++; if ({bus_drive, busy} !== 2'b01)
         $display("FAIL 8086_between: got drv/busy=%b want 01", {bus_drive, busy}); else passed++;
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'h43})
         $display("FAIL 8086_vector: got drv=%b data=%h want drv=1 data=43", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({bus_drive, freeze, busy, isr_clr, INT} !== 5'b0)
         $display("FAIL 8086_end: got drv/frz/busy/clr/INT=%b want 00000", {bus_drive, freeze, busy, isr_clr, INT}); else passed++;
      checks++; if (bus_data !== 8'h43) $display("FAIL 8086_data_hold: got %h want 43", bus_data); else passed++;
      step(1);
      checks++; if (INT !== 1'b1) $display("FAIL 8086_int_reassert: got %b want 1", INT); else passed++;
   endtask

   task automatic test_8080_interval4();
      do_reset();
      mode_8086 = 1'b0; interval4 = 1'b1; int_level = 3'd5; int_pending = 1'b1;
      addr_lo = 3'b101; addr_hi = 8'h12;
      step(1);
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'hCD})
         $display("FAIL i4_byte1: got drv=%b data=%h want drv=1 data=cd", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b0, 8'hCD})
         $display("FAIL i4_gap1: got drv=%b data=%h want drv=0 data=cd", bus_drive, bus_data); else passed++;
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'hB4})
         $display("FAIL i4_byte2: got drv=%b data=%h want drv=1 data=b4", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({bus_drive, busy} !== 2'b01)
         $display("FAIL i4_gap2: got drv/busy=%b want 01", {bus_drive, busy}); else passed++;
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'h12})
         $display("FAIL i4_byte3: got drv=%b data=%h want drv=1 data=12", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({bus_drive, freeze, busy} !== 3'b000)
         $display("FAIL i4_end: got drv/frz/busy=%b want 000", {bus_drive, freeze, busy}); else passed++;
   endtask

   task automatic test_8080_interval8_mode_latch();
      do_reset();
      mode_8086 = 1'b0; interval4 = 1'b0; int_level = 3'd2; int_pending = 1'b1;
      addr_lo = 3'b110; addr_hi = 8'h9A; vec_base = 5'h1F;
      step(1);
      INTA_n = 1'b0; step(1);
      // Mode and request changes after the first fall must be ignored.
      mode_8086 = 1'b1; int_level = 3'd0; int_pending = 1'b0;
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'hD0})
         $display("FAIL i8_byte2: got drv=%b data=%h want drv=1 data=d0", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if (busy !== 1'b1) $display("FAIL i8_still_busy: got %b want 1", busy); else passed++;
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'h9A})
         $display("FAIL i8_byte3: got drv=%b data=%h want drv=1 data=9a", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if (busy !== 1'b0) $display("FAIL i8_end: got busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_aeoi();
      do_reset();
      mode_8086 = 1'b1; aeoi = 1'b1; vec_base = 5'h08; int_level = 3'd6; int_pending = 1'b1;
      step(1);
      INTA_n = 1'b0; step(1);
      checks++; if ({isr_set, isr_level} !== {1'b1, 3'd6})
         $display("FAIL aeoi_set: got set=%b lvl=%0d want set=1 lvl=6", isr_set, isr_level); else passed++;
      aeoi = 1'b0;  // the latched aeoi must still produce the clear
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      checks++; if (isr_clr !== 1'b0) $display("FAIL aeoi_clr_early: got %b want 0", isr_clr); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({isr_clr, isr_level} !== {1'b1, 3'd6})
         $display("FAIL aeoi_clr: got clr=%b lvl=%0d want clr=1 lvl=6", isr_clr, isr_level); else passed++;
      step(1);
      checks++; if (isr_clr !== 1'b0) $display("FAIL aeoi_clr_pulse: got %b want 0", isr_clr); else passed++;
   endtask

   task automatic test_spurious();
      do_reset();
      mode_8086 = 1'b1; aeoi = 1'b1; vec_base = 5'h08; int_level = 3'd4; int_pending = 1'b1;
      step(1);
      int_pending = 1'b0; INTA_n = 1'b0; step(1);
      checks++; if ({isr_set, busy, freeze} !== 3'b011)
         $display("FAIL spur_ack1: got set/busy/frz=%b want 011", {isr_set, busy, freeze}); else passed++;
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'h47})
         $display("FAIL spur_vector: got drv=%b data=%h want drv=1 data=47", bus_drive, bus_data); else passed++;
      INTA_n = 1'b1; step(1);
      checks++; if ({isr_clr, busy} !== 2'b00)
         $display("FAIL spur_end: got clr/busy=%b want 00", {isr_clr, busy}); else passed++;
   endtask

   task automatic test_reset_mid_sequence();
      do_reset();
      mode_8086 = 1'b0; interval4 = 1'b1; int_level = 3'd1; int_pending = 1'b1;
      addr_lo = 3'b000; addr_hi = 8'h55;
      step(1);
      INTA_n = 1'b0; step(1);
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data} !== {1'b1, 8'h04})
         $display("FAIL rst_pre_byte2: got drv=%b data=%h want drv=1 data=04", bus_drive, bus_data); else passed++;
      reset = 1'b1; step(1);
      checks++; if ({INT, bus_data, bus_drive, freeze, isr_set, isr_clr, isr_level, busy} !== 16'h0)
         $display("FAIL rst_mid_outputs: got INT=%b data=%h drv=%b frz=%b busy=%b, want all 0",
                  INT, bus_data, bus_drive, freeze, busy);
      else passed++;
      INTA_n = 1'b1; step(1);
      reset = 1'b0; step(2);
      INTA_n = 1'b0; step(1);
      checks++; if ({bus_drive, bus_data, busy, isr_set} !== {1'b1, 8'hCD, 1'b1, 1'b1})
         $display("FAIL rst_fresh_ack1: got drv=%b data=%h busy=%b set=%b want drv=1 data=cd busy=1 set=1",
                  bus_drive, bus_data, busy, isr_set);
      else passed++;
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      checks++; if (bus_data !== 8'h04) $display("FAIL rst_fresh_byte2: got %h want 04", bus_data); else passed++;
   endtask

   initial begin
      test_reset();
      test_8086();
      test_8080_interval4();
      test_8080_interval8_mode_latch();
      test_aeoi();
      test_spurious();
      test_reset_mid_sequence();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
